// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed EXU requests into aligned doubleword memory accesses.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses return resp_err instead of being force-aligned.
module lsu_align (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic        req_ren,
   input  logic        req_wen,
   input  logic [1:0]  req_wdt,
   input  logic        req_sext,
   output logic [63:0] mem_raddr,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   output logic        mem_ren,
   output logic        mem_wen,
   input  logic [63:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

   state_t      r_state, w_next;
   logic [63:0] r_addr, r_wdata, r_rdata;
   logic        r_ren, r_wen, r_sext, r_err;
   logic [1:0]  r_wdt;

   logic        w_accept, w_illegal, w_misal, w_trap, w_access;
   logic [2:0]  w_lowmask;
   logic [7:0]  w_bytemask;
   logic [63:0] w_shifted, w_ext;

   assign w_accept  = req_valid && (r_state == S_IDLE);
   assign w_illegal = (req_ren == req_wen);

   always_comb begin
      w_lowmask = 3'b000;
      case (req_wdt)
         2'd0: w_lowmask = 3'b000;
         2'd1: w_lowmask = 3'b001;
         2'd2: w_lowmask = 3'b011;
         2'd3: w_lowmask = 3'b111;
         default: w_lowmask = 3'b000;
      endcase
   end

   assign w_misal = |(req_addr[2:0] & w_lowmask);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_trap = w_illegal | w_misal;
`else
   assign w_trap = w_illegal;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = w_trap ? S_RESP : S_ACCESS;
         S_ACCESS:  w_next = r_ren ? S_CAPTURE : S_RESP;
         S_CAPTURE: w_next = S_RESP;
         S_RESP:    if (resp_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Without the trap, the latched address is already size-aligned, so all later shifts use it directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_wdt   <= '0;
         r_sext  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= {req_addr[63:3], req_addr[2:0] & ~w_lowmask};
            r_wdata <= req_wdata;
            r_ren   <= req_ren;
            r_wen   <= req_wen;
            r_wdt   <= req_wdt;
            r_sext  <= req_sext;
            r_err   <= w_trap;
            r_rdata <= '0;
         end
         if (r_state == S_CAPTURE) r_rdata <= w_ext;
      end
   end

   assign w_shifted = mem_rdata >> {r_addr[2:0], 3'b000};

   always_comb begin
      w_ext      = w_shifted;
      w_bytemask = 8'hFF;
      case (r_wdt)
         2'd0: begin
            w_ext      = {{56{r_sext & w_shifted[7]}}, w_shifted[7:0]};
            w_bytemask = 8'h01;
         end
         2'd1: begin
            w_ext      = {{48{r_sext & w_shifted[15]}}, w_shifted[15:0]};
            w_bytemask = 8'h03;
         end
         2'd2: begin
            w_ext      = {{32{r_sext & w_shifted[31]}}, w_shifted[31:0]};
            w_bytemask = 8'h0F;
         end
         default: begin
            w_ext      = w_shifted;
            w_bytemask = 8'hFF;
         end
      endcase
   end

   assign w_access   = (r_state == S_ACCESS);
   assign req_ready  = (r_state == S_IDLE);
   assign mem_ren    = w_access & r_ren;
   assign mem_wen    = w_access & r_wen;
   assign mem_raddr  = {r_addr[63:3], 3'b000};
   assign mem_waddr  = {r_addr[63:3], 3'b000};
   assign mem_wmask  = mem_wen ? (w_bytemask << r_addr[2:0]) : '0;
   assign mem_wdata  = mem_wen ? (r_wdata << {r_addr[2:0], 3'b000}) : '0;
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed vector table, multi-cycle corner sequences,
// and randomized transactions checked against an arithmetic reference model.
module tb_lsu_align;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [63:0] req_addr, req_wdata;
   logic        req_ren, req_wen;
   logic [1:0]  req_wdt;
   logic        req_sext;
   logic [63:0] mem_raddr, mem_waddr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ren, mem_wen;
   logic [63:0] mem_rdata;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   lsu_align dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ren(req_ren), .req_wen(req_wen),
      .req_wdt(req_wdt), .req_sext(req_sext),
      .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic        ren;
      logic        wen;
      logic [1:0]  wdt;
      logic        sext;
      logic [63:0] wdata;
      logic [63:0] mem;
   } txn_t;

   typedef struct {
      int          lat;
      logic        err;
      logic [63:0] rdata;
      int          nren;
      int          nwen;
      logic [63:0] addr;
      logic [7:0]  wmask;
      logic [63:0] wdata;
   } obs_t;

   typedef struct {
      txn_t t;
      int   hold;
      obs_t e;
   } vec_t;

   int n_assert = 0;
   int n_fail   = 0;

   // Memory returns the requested doubleword one cycle after mem_ren, noise otherwise.
   logic [63:0] mem_dw;
   always @(posedge clk) mem_rdata <= mem_ren ? mem_dw : {$urandom, $urandom};

   int          ren_cnt = 0, wen_cnt = 0, viol = 0;
   logic [63:0] cap_raddr, cap_waddr, cap_wdata;
   logic [7:0]  cap_wmask;
   always @(negedge clk) begin
      if (mem_ren) begin ren_cnt++; cap_raddr = mem_raddr; end
      if (mem_wen) begin wen_cnt++; cap_waddr = mem_waddr; cap_wmask = mem_wmask; cap_wdata = mem_wdata; end
      if (!mem_wen && (mem_wmask != 8'h00 || mem_wdata != 64'h0)) viol++;
      if (mem_ren && mem_wen) viol++;
      if (mem_raddr[2:0] != 3'b000 || mem_waddr != mem_raddr) viol++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      end
   endtask

   function automatic txn_t mk_t(logic [63:0] a, logic r, logic w, logic [1:0] d, logic s,
                                 logic [63:0] wd, logic [63:0] m);
      txn_t t;
      t.addr = a; t.ren = r; t.wen = w; t.wdt = d; t.sext = s; t.wdata = wd; t.mem = m;
      return t;
   endfunction

   function automatic obs_t mk_e(int lat, logic err, logic [63:0] rd, int nr, int nw,
                                 logic [63:0] a, logic [7:0] wm, logic [63:0] wd);
      obs_t e;
      e.lat = lat; e.err = err; e.rdata = rd; e.nren = nr; e.nwen = nw;
      e.addr = a; e.wmask = wm; e.wdata = wd;
      return e;
   endfunction

   // Reference: size-aligned address, byte offset inside the doubleword, arithmetic extraction.
   function automatic obs_t model(txn_t t);
      obs_t        e;
      int unsigned size, off;
      logic [63:0] eff, v, lim;
      logic        illegal, mis;
      e = mk_e(1, 1'b1, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0);
      size    = 1 << t.wdt;
      illegal = (t.ren == t.wen);
      mis     = (t.addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (illegal || mis) return e;
`else
      if (illegal) return e;
`endif
      eff    = t.addr - (t.addr % size);
      off    = int'(eff % 8);
      e.addr = eff - off;
      e.err  = 1'b0;
      if (t.ren) begin
         v = t.mem >> (8 * off);
         if (size < 8) begin
            lim = 64'd1 << (8 * size);
            v   = v % lim;
            if (t.sext && v >= lim / 2) v = v - lim;
         end
         e.rdata = v;
         e.lat   = 3;
         e.nren  = 1;
      end else begin
         e.lat   = 2;
         e.nwen  = 1;
         e.wmask = 8'(((1 << size) - 1) << off);
         e.wdata = t.wdata << (8 * off);
      end
      return e;
   endfunction

   task automatic scramble_req();
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_ren   = 1'($urandom);
      req_wen   = 1'($urandom);
      req_wdt   = 2'($urandom);
      req_sext  = 1'($urandom);
   endtask

   task automatic run_txn(input txn_t t, input int hold, output obs_t o);
      int          w, b_ren, b_wen;
      logic [63:0] r0;
      logic        e0;
      o = mk_e(0, 1'b0, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0);
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      if (!req_ready) begin chk("idle_wait_timeout", 64'(req_ready), 64'h1); return; end
      mem_dw    = t.mem;
      req_addr  = t.addr;  req_wdata = t.wdata;
      req_ren   = t.ren;   req_wen   = t.wen;
      req_wdt   = t.wdt;   req_sext  = t.sext;
      req_valid = 1'b1;
      b_ren = ren_cnt; b_wen = wen_cnt;
      @(posedge clk);
      // Garbage on req_* while busy must not disturb the latched request.
      while (o.lat < 20) begin
         @(negedge clk);
         o.lat++;
         if (resp_valid) break;
         scramble_req();
         req_valid = 1'($urandom);
      end
      req_valid = 1'b0;
      if (!resp_valid) begin chk("resp_timeout", 64'(resp_valid), 64'h1); return; end
      o.rdata = resp_rdata;
      o.err   = resp_err;
      r0 = resp_rdata; e0 = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(resp_valid), 64'h1);
         chk("hold_rdata", resp_rdata, r0);
         chk("hold_err", 64'(resp_err), 64'(e0));
         chk("hold_req_ready", 64'(req_ready), 64'h0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      o.nren  = ren_cnt - b_ren;
      o.nwen  = wen_cnt - b_wen;
      o.addr  = (o.nwen != 0) ? cap_waddr : cap_raddr;
      o.wmask = cap_wmask;
      o.wdata = cap_wdata;
   endtask

   task automatic compare(input string tag, input obs_t o, input obs_t e);
      chk({tag, "_lat"},   64'(o.lat),  64'(e.lat));
      chk({tag, "_err"},   64'(o.err),  64'(e.err));
      chk({tag, "_rdata"}, o.rdata,     e.rdata);
      chk({tag, "_nren"},  64'(o.nren), 64'(e.nren));
      chk({tag, "_nwen"},  64'(o.nwen), 64'(e.nwen));
      if (e.nren + e.nwen != 0) chk({tag, "_addr"}, o.addr, e.addr);
      if (e.nwen != 0) begin
         chk({tag, "_wmask"}, 64'(o.wmask), 64'(e.wmask));
         chk({tag, "_wdata"}, o.wdata, e.wdata);
      end
   endtask

   initial begin
      vec_t        vecs[12];
      obs_t        o, e;
      txn_t        t;
      int          acc[8];
      int          n, b, r;
      logic [63:0] M, A;

      M = 64'h8877665544332211;
      A = 64'h0000_0000_8000_0000;
      vecs[0]  = '{mk_t(A + 3, 1, 0, 0, 0, 64'h0, M), 0, mk_e(3, 0, 64'h44, 1, 0, A, 8'h00, 64'h0)};
      vecs[1]  = '{mk_t(A + 4, 1, 0, 2, 1, 64'h0, M), 0, mk_e(3, 0, 64'hFFFF_FFFF_8877_6655, 1, 0, A, 8'h00, 64'h0)};
      vecs[2]  = '{mk_t(A + 4, 1, 0, 2, 0, 64'h0, M), 0, mk_e(3, 0, 64'h0000_0000_8877_6655, 1, 0, A, 8'h00, 64'h0)};
      vecs[3]  = '{mk_t(A + 6, 0, 1, 1, 0, 64'hBEEF, M), 0, mk_e(2, 0, 64'h0, 0, 1, A, 8'hC0, 64'hBEEF_0000_0000_0000)};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[4]  = '{mk_t(A + 2, 1, 0, 2, 0, 64'h0, M), 0, mk_e(1, 1, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0)};
`else
      vecs[4]  = '{mk_t(A + 2, 1, 0, 2, 0, 64'h0, M), 0, mk_e(3, 0, 64'h4433_2211, 1, 0, A, 8'h00, 64'h0)};
`endif
      vecs[5]  = '{mk_t(A, 1, 0, 3, 1, 64'h0, M), 0, mk_e(3, 0, M, 1, 0, A, 8'h00, 64'h0)};
      vecs[6]  = '{mk_t(A + 6, 1, 0, 1, 1, 64'h0, M), 0, mk_e(3, 0, 64'hFFFF_FFFF_FFFF_8877, 1, 0, A, 8'h00, 64'h0)};
      vecs[7]  = '{mk_t(A + 1, 1, 0, 0, 1, 64'h0, M), 0, mk_e(3, 0, 64'h22, 1, 0, A, 8'h00, 64'h0)};
      vecs[8]  = '{mk_t(A, 0, 0, 3, 0, 64'h0, M), 0, mk_e(1, 1, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0)};
      vecs[9]  = '{mk_t(64'h1234_5677, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFA5, M), 0,
                   mk_e(2, 0, 64'h0, 0, 1, 64'h1234_5670, 8'h80, 64'hA500_0000_0000_0000)};
      vecs[10] = '{mk_t(A + 8, 0, 1, 3, 0, 64'h0123_4567_89AB_CDEF, M), 5,
                   mk_e(2, 0, 64'h0, 0, 1, A + 8, 8'hFF, 64'h0123_4567_89AB_CDEF)};
      vecs[11] = '{mk_t(A + 8, 1, 1, 3, 0, 64'h0, M), 0, mk_e(1, 1, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0)};

      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; mem_dw = '0;
      req_addr = '0; req_wdata = '0; req_ren = 1'b0; req_wen = 1'b0; req_wdt = '0; req_sext = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'h1);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_resp_err", 64'(resp_err), 64'h0);
      chk("rst_resp_rdata", resp_rdata, 64'h0);
      chk("rst_mem_strobes", {62'h0, mem_ren, mem_wen}, 64'h0);
      chk("rst_mem_wmask", 64'(mem_wmask), 64'h0);

      foreach (vecs[i]) begin
         run_txn(vecs[i].t, vecs[i].hold, o);
         compare($sformatf("vec%0d", i), o, vecs[i].e);
      end

      // Back-to-back throughput with req_valid and resp_ready held high.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         mem_dw = M; req_addr = A; req_wdt = 2'd3; req_sext = 1'b0; req_wdata = 64'h55;
         req_ren = (k == 0); req_wen = (k != 0);
         req_valid = 1'b1; resp_ready = 1'b1;
         n = 0;
         for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            if (req_ready && n < 8) begin acc[n] = i; n++; end
         end
         req_valid = 1'b0;
         repeat (5) @(negedge clk);
         resp_ready = 1'b0;
         chk($sformatf("tp%0d_count", k), 64'(n >= 3), 64'h1);
         if (n >= 3) begin
            chk($sformatf("tp%0d_gap1", k), 64'(acc[1] - acc[0]), (k == 0) ? 64'd4 : 64'd3);
            chk($sformatf("tp%0d_gap2", k), 64'(acc[2] - acc[1]), (k == 0) ? 64'd4 : 64'd3);
         end
      end

      // Reset during ACCESS of a store abandons it.
      @(negedge clk);
      req_addr = A + 16; req_wdata = 64'hDEAD; req_ren = 1'b0; req_wen = 1'b1; req_wdt = 2'd3;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mr_access_wen", 64'(mem_wen), 64'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_req_ready", 64'(req_ready), 64'h1);
      chk("mr_mem_wen", 64'(mem_wen), 64'h0);
      chk("mr_resp_valid", 64'(resp_valid), 64'h0);
      chk("mr_resp_err", 64'(resp_err), 64'h0);
      rst = 1'b0; resp_ready = 1'b1;
      b = wen_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mr_no_resp", 64'(resp_valid), 64'h0);
      end
      chk("mr_no_wen", 64'(wen_cnt - b), 64'h0);
      resp_ready = 1'b0;

      for (int i = 0; i < 300; i++) begin
         r = int'($urandom % 8);
         t.addr  = {$urandom, $urandom};
         t.wdata = {$urandom, $urandom};
         t.mem   = {$urandom, $urandom};
         t.wdt   = 2'($urandom);
         t.sext  = 1'($urandom);
         t.ren   = (r <= 2) || (r == 7);
         t.wen   = (r >= 3 && r <= 5) || (r == 7);
         run_txn(t, int'($urandom % 3), o);
         e = model(t);
         compare($sformatf("rnd%0d", i), o, e);
      end

      chk("strobe_violations", 64'(viol), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: req_valid in 1 / req_ready out 1  request handshake from EXU.
REQ-004 SHALL have ports: req_addr in 64 byte address; req_wdata in 64 store data in bits [8*size-1:0]; req_ren in 1; req_wen in 1.
REQ-005 SHALL have ports: req_wdt in 2 width (0=8b,1=16b,2=32b,3=64b); req_sext in 1 sign-extend load when 1.
REQ-006 SHALL have ports: mem_raddr out 64; mem_waddr out 64; mem_wdata out 64; mem_wmask out 8; mem_ren out 1; mem_wen out 1; mem_rdata in 64 raw aligned doubleword.
REQ-007 SHALL have ports: resp_valid out 1 / resp_ready in 1 response handshake; resp_rdata out 64; resp_err out 1.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP; req_ready=1 only in IDLE.
REQ-009 SHALL latch all req_* fields on req_valid&&req_ready; IDLE->ACCESS for a legal load or store.
REQ-010 SHALL in ACCESS drive mem_ren=req_ren or mem_wen=req_wen for exactly one cycle; both strobes 0 in every other state.
REQ-011 SHALL drive mem_raddr=mem_waddr=addr with bits [2:0] cleared.
REQ-012 SHALL drive mem_wmask=((1<<size)-1)<<addr[2:0] and mem_wdata=wdata<<(8*addr[2:0]), size=1<<req_wdt bytes; both 0 outside ACCESS.
REQ-013 SHALL treat mem_rdata as valid the cycle after mem_ren; in CAPTURE register mem_rdata>>(8*addr[2:0]), truncate to size, zero- or sign-extend per req_sext (ignored for 64b).
REQ-014 SHALL go ACCESS->CAPTURE->RESP for loads and ACCESS->RESP for stores; store resp_rdata=0.
REQ-015 SHALL hold resp_valid=1 in RESP with resp_rdata/resp_err stable until resp_ready; RESP->IDLE on resp_valid&&resp_ready.
REQ-016 SHALL minimum latency: accept cycle N, resp_valid at N+3 (load), N+2 (store); resp_ready held 1 gives back-to-back throughput of one request per 4 (load) / 3 (store) cycles.
REQ-017 SHALL treat req_ren==req_wen (both 0 or both 1) as illegal: IDLE->RESP, no memory strobe, resp_err=1, resp_rdata=0.
REQ-018 SHALL ignore req_* while not in IDLE; latched values not affected.

Reset
REQ-019 SHALL on rst: state=IDLE, all latched fields 0, mem_ren=mem_wen=0, mem_wmask=0, resp_valid=0, resp_err=0, resp_rdata=0; req_ready=1 from the first cycle after reset.
REQ-020 SHALL abandon any transaction when rst is asserted mid-operation; no mem_wen pulse in the cycle following the reset edge, and no response is produced.

Configuration
REQ-021 SHALL with LSU_MISALIGN_TRAP_EN defined: access with addr not a multiple of size goes IDLE->RESP with resp_err=1, resp_rdata=0, no memory strobe.
REQ-022 SHALL without LSU_MISALIGN_TRAP_EN: low log2(size) bits of addr are forced to 0, the access proceeds normally, and resp_err is 1 only for REQ-017.

Verification
REQ-023 SHALL cover: mem doubleword 0x8877665544332211, load addr 0x80000003 wdt=0 sext=0 -> mem_raddr=0x80000000, resp_rdata=0x44, resp_valid 3 cycles after accept.
REQ-024 SHALL cover: same memory, load addr 0x80000004 wdt=2 sext=1 -> resp_rdata=0xFFFFFFFF88776655 (sext=0 -> 0x0000000088776655).
REQ-025 SHALL cover: store addr 0x80000006 wdt=1 wdata=0xBEEF -> one-cycle mem_wen, mem_wmask=0xC0, mem_wdata=0xBEEF000000000000, resp_err=0.
REQ-026 SHALL cover: load addr 0x80000002 wdt=2 -> trap build: resp_err=1, no mem_ren; non-trap build: mem_raddr=0x80000000, resp_rdata from bytes [3:0], resp_err=0.
REQ-027 SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_ready=0; then req_ren=req_wen=1 -> resp_err=1, no strobe.
REQ-028 SHALL cover: rst asserted in ACCESS of a store -> next cycle IDLE, req_ready=1, mem_wen=0, resp_valid stays 0.
